// File: rtl/fwd_pkg.sv
// Shared types and constants for the Core101 ID-stage forwarding / load-use hazard unit.
package fwd_pkg;

  // Tracker entries hold register addresses of up to this width; wider ADDR_W is unsupported.
  localparam int MAX_ADDR_W = 8;

  localparam int STG_IS = 1;
  localparam int STG_EX = 2;
  localparam int STG_WB = 3;

  localparam int SEL_RF = 0;

  localparam int                     STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  typedef logic [MAX_ADDR_W-1:0] rd_t;

  typedef struct packed {
    logic valid;
    rd_t  rd;
    logic is_load;
  } trk_entry_t;

  // x0 writers never produce a value worth bypassing.
  function automatic logic eligible(trk_entry_t e);
    return e.valid && (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_lane_match.sv
// One source lane: prioritised compare of rs against every tracked stage, youngest first.
module fwd_lane_match
  import fwd_pkg::*;
#(
  parameter int ADDR_W           = 5,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 3
) (
  input  logic [ADDR_W-1:0]         rs_i,
  input  trk_entry_t [NUM_STAGES:1] entries_i,
  output logic [NUM_STAGES:0]       sel_o,
  output logic                      hazard_o
);

  rd_t  rs_ext;
  logic found;

  assign rs_ext = rd_t'(rs_i);

  // NOTE: every output of a combinational block gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    sel_o    = '0;
    hazard_o = 1'b0;
    found    = 1'b0;
    if (rs_ext != '0) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        if (!found && eligible(entries_i[k]) && (entries_i[k].rd == rs_ext)) begin
          found = 1'b1;
          // The youngest match decides alone: an unready load here hides any older copy.
          if (entries_i[k].is_load && (k < LOAD_READY_STAGE)) begin
            hazard_o = 1'b1;
          end else begin
            sel_o[k] = 1'b1;
          end
        end
      end
    end
    sel_o[SEL_RF] = ~|sel_o[NUM_STAGES:1];
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit with its own in-flight destination tracker.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W           = 5,
  parameter int NUM_SRC          = 2,
  parameter int NUM_STAGES       = STG_WB,
  parameter int LOAD_READY_STAGE = STG_WB
) (
  input  logic                                clock_in,
  input  logic                                reset_in,
  input  logic                                id_valid_in,
  input  logic [ADDR_W-1:0]                   id_rd_addr_in,
  input  logic                                id_rd_we_in,
  input  logic                                id_is_load_in,
  input  logic [NUM_SRC*ADDR_W-1:0]           id_rs_addr_in,
  input  logic                                hold_in,
  input  logic                                flush_in,
  output logic [NUM_SRC*(NUM_STAGES+1)-1:0]   fwd_sel_out,
  output logic                                stall_out,
  output logic [STALL_CNT_W-1:0]              stall_count_out
);

  localparam int SEL_W = NUM_STAGES + 1;

  trk_entry_t [NUM_STAGES:1] trk_q, trk_d;
  trk_entry_t                id_entry;
  logic [STALL_CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]        lane_hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_lane_match #(
      .ADDR_W          (ADDR_W),
      .NUM_STAGES      (NUM_STAGES),
      .LOAD_READY_STAGE(LOAD_READY_STAGE)
    ) u_lane (
      .rs_i     (id_rs_addr_in[i*ADDR_W +: ADDR_W]),
      .entries_i(trk_q),
      .sel_o    (fwd_sel_out[i*SEL_W +: SEL_W]),
      .hazard_o (lane_hazard[i])
    );
  end

  assign stall_out = id_valid_in & (|lane_hazard);

  assign id_entry = '{valid:   id_valid_in & id_rd_we_in,
                      rd:      rd_t'(id_rd_addr_in),
                      is_load: id_is_load_in};

  // Flush beats hold beats stall; a stalled ID injects a bubble instead of its own entry.
  always_comb begin
    trk_d = trk_q;
    if (flush_in) begin
      trk_d = '0;
    end else if (!hold_in) begin
      for (int k = NUM_STAGES; k >= STG_EX; k--) begin
        trk_d[k] = trk_q[k-1];
      end
      trk_d[STG_IS] = stall_out ? trk_entry_t'('0) : id_entry;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_out && !hold_in && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples the
  // pre-edge values regardless of block ordering. The tracker is a few flops, not a memory,
  // so it is cleared by reset along with the counter.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_out = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: default instance plus a deep instance for saturation.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic [7:0]  sel;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [16:0] sel;
    logic        stall;
    logic [15:0] cnt;
  } sat_exp_t;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        hold;
    logic        flush;
    logic [7:0]  sel;
    logic        stall;
    logic [15:0] cnt;
  } vec_t;

  logic        clk;
  logic        reset_in, id_valid_in, id_rd_we_in, id_is_load_in, hold_in, flush_in;
  logic [4:0]  id_rd_addr_in;
  logic [9:0]  id_rs_addr_in;
  logic [7:0]  fwd_sel_out;
  logic        stall_out;
  logic [15:0] stall_count_out;

  logic        sat_reset, sat_valid, sat_we, sat_load, sat_hold, sat_flush;
  logic [4:0]  sat_rd, sat_rs;
  logic [16:0] sat_sel;
  logic        sat_stall;
  logic [15:0] sat_cnt;

  exp_t     exp_q[$];
  sat_exp_t sat_q[$];
  int       n_assert = 0;
  int       n_fail   = 0;

  fwd_hazard_unit dut (
    .clock_in       (clk),
    .reset_in       (reset_in),
    .id_valid_in    (id_valid_in),
    .id_rd_addr_in  (id_rd_addr_in),
    .id_rd_we_in    (id_rd_we_in),
    .id_is_load_in  (id_is_load_in),
    .id_rs_addr_in  (id_rs_addr_in),
    .hold_in        (hold_in),
    .flush_in       (flush_in),
    .fwd_sel_out    (fwd_sel_out),
    .stall_out      (stall_out),
    .stall_count_out(stall_count_out)
  );

  // Deep tracker: a load stalls 15 of every 16 cycles, so the counter saturates quickly.
  fwd_hazard_unit #(
    .ADDR_W(5), .NUM_SRC(1), .NUM_STAGES(16), .LOAD_READY_STAGE(16)
  ) dut_sat (
    .clock_in       (clk),
    .reset_in       (sat_reset),
    .id_valid_in    (sat_valid),
    .id_rd_addr_in  (sat_rd),
    .id_rd_we_in    (sat_we),
    .id_is_load_in  (sat_load),
    .id_rs_addr_in  (sat_rs),
    .hold_in        (sat_hold),
    .flush_in       (sat_flush),
    .fwd_sel_out    (sat_sel),
    .stall_out      (sat_stall),
    .stall_count_out(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(logic rst, logic v, logic [4:0] rd, logic we, logic ld,
                              logic [4:0] rs0, logic [4:0] rs1, logic hold, logic flush,
                              logic [7:0] sel, logic stall, logic [15:0] cnt);
    return '{rst: rst, v: v, rd: rd, we: we, ld: ld, rs0: rs0, rs1: rs1, hold: hold,
             flush: flush, sel: sel, stall: stall, cnt: cnt};
  endfunction

  task automatic drive(input vec_t v);
    reset_in      = v.rst;
    id_valid_in   = v.v;
    id_rd_addr_in = v.rd;
    id_rd_we_in   = v.we;
    id_is_load_in = v.ld;
    id_rs_addr_in = {v.rs1, v.rs0};
    hold_in       = v.hold;
    flush_in      = v.flush;
    exp_q.push_back('{sel: v.sel, stall: v.stall, cnt: v.cnt});
  endtask

  task automatic do_reset();
    reset_in = 1'b1; id_valid_in = 1'b0; id_rd_addr_in = '0; id_rd_we_in = 1'b0;
    id_is_load_in = 1'b0; id_rs_addr_in = '0; hold_in = 1'b0; flush_in = 1'b0;
    @(posedge clk); #1;
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0,  5, 31, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 3, 1, 0,  3,  3, 0, 0, 8'h11, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_fwd();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1, 5, 1, 0,  0, 0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 6, 1, 0,  5, 5, 0, 0, 8'h22, 0, 0));
    v.push_back(mk(0, 1, 0, 1, 0,  5, 6, 0, 0, 8'h24, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0,  0, 5, 0, 0, 8'h81, 0, 0));
    v.push_back(mk(0, 1, 7, 0, 0,  6, 5, 0, 0, 8'h18, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0,  7, 7, 0, 0, 8'h11, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL alu_fwd[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1, 7, 1, 0,  0, 0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 8, 1, 0,  0, 0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 7, 1, 0,  8, 7, 0, 0, 8'h42, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0,  8, 7, 0, 0, 8'h24, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL youngest[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1,  9, 1, 1,  0,  0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9,  3, 0, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9,  3, 0, 0, 8'h11, 1, 1));
    v.push_back(mk(0, 1, 10, 1, 0,  9,  3, 0, 0, 8'h18, 0, 2));
    v.push_back(mk(0, 0,  0, 0, 0,  9, 10, 0, 0, 8'h21, 0, 2));
    v.push_back(mk(0, 1, 11, 1, 1,  0,  0, 0, 0, 8'h11, 0, 2));
    v.push_back(mk(0, 0,  0, 0, 0, 11, 11, 0, 0, 8'h11, 0, 2));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_hides();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1, 12, 1, 0,   0,  0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 0,  0, 0, 0,   0,  0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 12, 1, 1,   0, 12, 0, 0, 8'h41, 0, 0));
    v.push_back(mk(0, 1, 13, 0, 0,  12,  0, 0, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 13, 0, 0,  12,  0, 0, 0, 8'h11, 1, 1));
    v.push_back(mk(0, 1, 13, 0, 0,  12,  0, 0, 0, 8'h18, 0, 2));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL load_hides[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1,  9, 1, 1,  0, 0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 0, 1, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 0, 1, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 0, 1, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 0, 0, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 0, 0, 0, 8'h11, 1, 1));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 0, 0, 0, 8'h18, 0, 2));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL hold[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1,  9, 1, 1,  0, 0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 10, 0, 0,  9, 9, 0, 0, 8'h11, 1, 0));
    v.push_back(mk(0, 1, 10, 0, 0,  9, 9, 0, 1, 8'h11, 1, 1));
    v.push_back(mk(0, 1, 10, 0, 0,  9, 9, 0, 0, 8'h11, 0, 2));
    v.push_back(mk(0, 1,  4, 1, 0,  9, 0, 0, 0, 8'h11, 0, 2));
    v.push_back(mk(0, 0,  0, 0, 0,  4, 0, 1, 1, 8'h12, 0, 2));
    v.push_back(mk(0, 0,  0, 0, 0,  4, 4, 0, 0, 8'h11, 0, 2));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL flush[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    vec_t v[$];
    exp_t e;
    do_reset();
    v.push_back(mk(0, 1,  9, 1, 1,  0, 0, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 9, 0, 0, 8'h11, 1, 0));
    v.push_back(mk(1, 1, 10, 1, 0,  9, 9, 0, 0, 8'h11, 1, 1));
    v.push_back(mk(0, 1, 10, 1, 0,  9, 9, 0, 0, 8'h11, 0, 0));
    v.push_back(mk(0, 0,  0, 0, 0, 10, 9, 0, 0, 8'h12, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_assert++;
      if ({fwd_sel_out, stall_out, stall_count_out} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_stall[%0d]: got sel=%b stall=%b cnt=%0d, required sel=%b stall=%b cnt=%0d",
                 i, fwd_sel_out, stall_out, stall_count_out, e.sel, e.stall, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // ID repeatedly presents "load x9 reading x9": cycle c stalls iff c >= 1 and c % 16 != 0.
  task automatic test_saturation();
    sat_exp_t    e;
    int          c      = 0;
    int          stalls = 0;
    logic        exp_stall;
    logic        chk;
    logic [15:0] exp_cnt;
    logic [16:0] exp_sel;
    sat_valid = 1'b1; sat_we = 1'b1; sat_load = 1'b1; sat_rd = 5'd9; sat_rs = 5'd9;
    sat_hold = 1'b0; sat_flush = 1'b0; sat_reset = 1'b1;
    @(posedge clk); #1;
    sat_reset = 1'b0;
    while (stalls < 65540 && c < 80000) begin
      exp_stall = (c >= 1) && (c % 16 != 0);
      exp_sel   = (c >= 16 && c % 16 == 0) ? 17'h10000 : 17'h00001;
      exp_cnt   = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
      chk       = (c <= 16) || (exp_stall && (stalls == 100 || stalls == 65535));
      if (chk) sat_q.push_back('{sel: exp_sel, stall: exp_stall, cnt: exp_cnt});
      @(negedge clk);
      if (chk) begin
        e = sat_q.pop_front();
        n_assert++;
        if ({sat_sel, sat_stall, sat_cnt} !== e) begin
          n_fail++;
          $display("FAIL saturation[c=%0d]: got sel=%h stall=%b cnt=%0d, required sel=%h stall=%b cnt=%0d",
                   c, sat_sel, sat_stall, sat_cnt, e.sel, e.stall, e.cnt);
        end
      end
      if (exp_stall) stalls++;
      c++;
      @(posedge clk); #1;
    end
    exp_stall = (c % 16 != 0);
    exp_sel   = exp_stall ? 17'h00001 : 17'h10000;
    sat_q.push_back('{sel: exp_sel, stall: exp_stall, cnt: 16'hFFFF});
    @(negedge clk);
    e = sat_q.pop_front();
    n_assert++;
    if ({sat_sel, sat_stall, sat_cnt} !== e) begin
      n_fail++;
      $display("FAIL saturation_final[stalls=%0d]: got sel=%h stall=%b cnt=%h, required sel=%h stall=%b cnt=%h",
               stalls, sat_sel, sat_stall, sat_cnt, e.sel, e.stall, e.cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_in = 1'b1; id_valid_in = 1'b0; id_rd_addr_in = '0; id_rd_we_in = 1'b0;
    id_is_load_in = 1'b0; id_rs_addr_in = '0; hold_in = 1'b0; flush_in = 1'b0;
    sat_reset = 1'b1; sat_valid = 1'b0; sat_rd = '0; sat_we = 1'b0; sat_load = 1'b0;
    sat_rs = '0; sat_hold = 1'b0; sat_flush = 1'b0;

    test_reset();
    test_alu_fwd();
    test_youngest();
    test_load_use();
    test_load_hides();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the Core101 pipeline, sitting in the decode (ID) stage. Unlike a purely combinational comparator fed with downstream destination addresses, it tracks in-flight destination registers itself in an internal shift pipeline. It qualifies matches by write-enable and x0, and resolves multiple matches by youngest-stage priority. It produces one-hot bypass selects for NUM_SRC source operands, inserts bubbles on load-use hazards, and keeps a saturating stall counter.

## Interface
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of source operands checked in ID
- NUM_STAGES, 3, tracked stages downstream of ID (1=IS, 2=EX, 3=WB)
- LOAD_READY_STAGE, 3, first stage index from which load data may be forwarded (1..NUM_STAGES)
- clock_in  input  1  system clock, rising edge
- reset_in  input  1  synchronous, active-high reset
- id_valid_in  input  1  ID holds a valid instruction
- id_rd_addr_in  input  ADDR_W  destination of ID instruction
- id_rd_we_in  input  1  ID instruction writes rd
- id_is_load_in  input  1  ID instruction is a load
- id_rs_addr_in  input  NUM_SRC*ADDR_W  source addresses, lane i at [i*ADDR_W +: ADDR_W]
- hold_in  input  1  external pipeline freeze
- flush_in  input  1  squash all in-flight instructions
- fwd_sel_out  output  NUM_SRC*(NUM_STAGES+1)  per lane one-hot: bit 0 = register file, bit k = stage k
- stall_out  output  1  load-use hazard, ID must hold
- stall_count_out  output  16  saturating count of stall cycles

## Operation
- Tracker: NUM_STAGES entries {valid, rd, is_load}; entry k = instruction in stage k.
- Entry eligible for match only if valid and rd != 0.
- Per lane i: rs == 0 -> select bit 0. Otherwise find the lowest k (youngest) with an eligible entry whose rd == rs.
  - None found -> bit 0.
  - Entry k is a load with k < LOAD_READY_STAGE -> lane hazard; lane select = bit 0.
  - Otherwise -> bit k.
- Lower matches hide older ones: an unready load at k=1 stalls even if stage 3 also matches.
- stall_out = OR of lane hazards, gated by id_valid_in.
- Update priority at rising edge: reset_in > flush_in > hold_in > stall_out > normal.
  - reset/flush: all entries invalid.
  - hold: all entries unchanged.
  - stall: entries shift k -> k+1 (last drops), entry 1 := bubble (invalid).
  - normal: shift; entry 1 := {id_valid_in & id_rd_we_in, id_rd_addr_in, id_is_load_in}.
- stall_count_out increments when stall_out=1 and hold_in=0; saturates at 0xFFFF; cleared only by reset, not by flush.

## Timing
- fwd_sel_out and stall_out are combinational from tracker state and ID inputs; same-cycle usage in ID.
- The tracker reflects an ID instruction one cycle after it advances.
- Reset values: all entries invalid; every lane of fwd_sel_out = bit 0 (i.e. …0001 per lane); stall_out = 0; stall_count_out = 0.
- Load-use with defaults: a load at stage 1 stalls 2 cycles (stage 1, then 2) and forwards from stage 3 in the third cycle.
- flush_in and stall in the same cycle: flush wins, no bubble bookkeeping remains.
- flush_in takes effect at the edge; selects in the flush cycle still reflect pre-flush state.
- Reset mid-stall: next cycle stall_out = 0, counter = 0.

## Structure
- Shared package fwd_pkg: tracker entry typedef {valid, rd, is_load}, stage index constants (STG_IS=1, STG_EX=2, STG_WB=3), select bit position for register file (0).
- Sub-module fwd_lane_match: one lane's prioritised comparator (rs vs NUM_STAGES entries -> one-hot select + hazard), generated NUM_SRC times. Tracker shift register and counter stay in the top.

## Test plan
- Reset, then no traffic -> fwd_sel_out = 8'b0001_0001, stall_out = 0, stall_count_out = 0.
- ALU writes x5, then next instruction reads rs1=x5, rs2=x5 -> both lanes select bit 1 (0010); one cycle later (if unrelated instruction between) bit 2; rd=x0 writer and rs=x0 always give bit 0.
- x7 written by stage 1 and stage 3 simultaneously, read x7 -> bit 1 (youngest wins).
- Load to x9 followed by reader of x9 -> stall_out high 2 cycles, bubbles inserted, then lane selects bit 3; stall_count_out = 2.
- Load-use with hold_in=1 for 3 cycles -> stall_out stays high, tracker frozen, counter unchanged during hold.
- flush_in during a load-use stall -> next cycle stall_out = 0, all lanes bit 0, counter retained; 65540 forced stall cycles -> counter = 0xFFFF.
